// File: rtl/tau_rom_pkg.sv
// Shared types and constants for the ROM port arbiter slice.
package tau_rom_pkg;

  typedef logic rom_port_id_t;

  localparam rom_port_id_t ROM_PORT_FETCH = 1'b0;
  localparam rom_port_id_t ROM_PORT_DATA  = 1'b1;

  localparam int unsigned ROM_ADDR_WIDTH = 8;
  localparam int unsigned ROM_DATA_WIDTH = 8;

endpackage

// File: rtl/rom_rr_arbiter2.sv
// Two-way round-robin grant logic; purely combinational, history register lives in the parent.
module rom_rr_arbiter2
  import tau_rom_pkg::*;
(
  input  logic         valid_0,
  input  logic         valid_1,
  input  rom_port_id_t last_grant,
  output logic         grant_0,
  output logic         grant_1,
  output rom_port_id_t grant_id
);

  always_comb begin
    grant_0  = 1'b0;
    grant_1  = 1'b0;
    grant_id = ROM_PORT_FETCH;
    if (valid_0 && valid_1) begin
      // Contention goes to whichever port did not win last time.
      if (last_grant == ROM_PORT_DATA) begin
        grant_0 = 1'b1;
      end else begin
        grant_1  = 1'b1;
        grant_id = ROM_PORT_DATA;
      end
    end else if (valid_0) begin
      grant_0 = 1'b1;
    end else if (valid_1) begin
      grant_1  = 1'b1;
      grant_id = ROM_PORT_DATA;
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one 1-cycle-latency ROM between fetch (port 0) and load (port 1) ports.
// Optional TAU_ROM_ARB_BOUNDS_CHECK_EN adds resp_error for addresses >= MEMORY_DEPTH.
module rom_port_arbiter
  import tau_rom_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ROM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = ROM_DATA_WIDTH,
  parameter int unsigned MEMORY_DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid_0,
  input  logic                  req_valid_1,
  input  logic [ADDR_WIDTH-1:0] req_address_0,
  input  logic [ADDR_WIDTH-1:0] req_address_1,
  output logic                  req_ready_0,
  output logic                  req_ready_1,
  output logic                  resp_valid_0,
  output logic                  resp_valid_1,
  output logic [DATA_WIDTH-1:0] resp_data,
`ifdef TAU_ROM_ARB_BOUNDS_CHECK_EN
  output logic                  resp_error,
`endif
  output logic                  rom_read_enable,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_data
);

  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(MEMORY_DEPTH);

  logic                  grant_0;
  logic                  grant_1;
  rom_port_id_t          grant_id;
  logic                  any_grant;
  logic                  addr_error;
  logic [ADDR_WIDTH-1:0] granted_addr;

  logic                  pend_valid;
  rom_port_id_t          pend_id;
  logic                  pend_error;
  rom_port_id_t          last_grant;

  rom_rr_arbiter2 u_arbiter (
    .valid_0    (req_valid_0),
    .valid_1    (req_valid_1),
    .last_grant (last_grant),
    .grant_0    (grant_0),
    .grant_1    (grant_1),
    .grant_id   (grant_id)
  );

  assign any_grant    = grant_0 | grant_1;
  assign granted_addr = (grant_id == ROM_PORT_DATA) ? req_address_1 : req_address_0;
  assign req_ready_0  = grant_0;
  assign req_ready_1  = grant_1;

`ifdef TAU_ROM_ARB_BOUNDS_CHECK_EN
  // Out-of-range requests are accepted but never reach the ROM.
  assign addr_error = any_grant && ({1'b0, granted_addr} >= DEPTH_LIMIT);
`else
  logic unused_depth;
  assign unused_depth = ^DEPTH_LIMIT;
  assign addr_error   = 1'b0;
`endif

  assign rom_read_enable = any_grant && !addr_error;
  assign rom_address     = rom_read_enable ? granted_addr : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid <= 1'b0;
      pend_id    <= ROM_PORT_FETCH;
      pend_error <= 1'b0;
      last_grant <= ROM_PORT_DATA;
    end else begin
      pend_valid <= any_grant;
      pend_id    <= grant_id;
      pend_error <= addr_error;
      if (any_grant) begin
        last_grant <= grant_id;
      end
    end
  end

  assign resp_valid_0 = pend_valid && (pend_id == ROM_PORT_FETCH);
  assign resp_valid_1 = pend_valid && (pend_id == ROM_PORT_DATA);
  assign resp_data    = (pend_valid && !pend_error) ? rom_data : '0;
`ifdef TAU_ROM_ARB_BOUNDS_CHECK_EN
  assign resp_error   = pend_valid && pend_error;
`endif

  onehot_resp: assert property (@(posedge clock) disable iff (!reset_n)
    !(resp_valid_0 && resp_valid_1));

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter with a registered-output ROM model.
module tb_rom_port_arbiter;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid_0 = 1'b0;
  logic       req_valid_1 = 1'b0;
  logic [7:0] req_address_0 = '0;
  logic [7:0] req_address_1 = '0;
  logic       req_ready_0;
  logic       req_ready_1;
  logic       resp_valid_0;
  logic       resp_valid_1;
  logic [7:0] resp_data;
  logic       resp_error;
  logic       rom_read_enable;
  logic [7:0] rom_address;
  logic [7:0] rom_data = '0;

  logic [7:0] rom [256];

  typedef struct {
    logic       port;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t sb[$];
  logic model_last = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  rom_port_arbiter dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .req_valid_0     (req_valid_0),
    .req_valid_1     (req_valid_1),
    .req_address_0   (req_address_0),
    .req_address_1   (req_address_1),
    .req_ready_0     (req_ready_0),
    .req_ready_1     (req_ready_1),
    .resp_valid_0    (resp_valid_0),
    .resp_valid_1    (resp_valid_1),
    .resp_data       (resp_data),
`ifdef TAU_ROM_ARB_BOUNDS_CHECK_EN
    .resp_error      (resp_error),
`endif
    .rom_read_enable (rom_read_enable),
    .rom_address     (rom_address),
    .rom_data        (rom_data)
  );

`ifndef TAU_ROM_ARB_BOUNDS_CHECK_EN
  assign resp_error = 1'b0;
`endif

  always @(posedge clock) begin
    if (rom_read_enable) rom_data <= rom[rom_address];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: compare due responses, then predict this cycle's grant.
  always @(negedge clock) begin
    logic       g0;
    logic       g1;
    logic [7:0] gaddr;
    logic       gerr;
    exp_t       e;
    if (!reset_n) begin
      sb.delete();
      model_last = 1'b1;
      check_eq("rst_resp_valid_0", 32'(resp_valid_0), 0);
      check_eq("rst_resp_valid_1", 32'(resp_valid_1), 0);
      check_eq("rst_rom_read_enable", 32'(rom_read_enable), 0);
    end else begin
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("resp_valid_0", 32'(resp_valid_0), 32'(!e.port));
        check_eq("resp_valid_1", 32'(resp_valid_1), 32'(e.port));
        check_eq("resp_data", 32'(resp_data), 32'(e.data));
        check_eq("resp_error", 32'(resp_error), 32'(e.err));
      end else begin
        check_eq("idle_resp_valid_0", 32'(resp_valid_0), 0);
        check_eq("idle_resp_valid_1", 32'(resp_valid_1), 0);
        check_eq("idle_resp_data", 32'(resp_data), 0);
      end
      g0 = req_valid_0 && (!req_valid_1 || model_last);
      g1 = req_valid_1 && !g0;
      gaddr = g1 ? req_address_1 : req_address_0;
`ifdef TAU_ROM_ARB_BOUNDS_CHECK_EN
      gerr = (g0 || g1) && (gaddr >= 8'd8);
`else
      gerr = 1'b0;
`endif
      check_eq("req_ready_0", 32'(req_ready_0), 32'(g0));
      check_eq("req_ready_1", 32'(req_ready_1), 32'(g1));
      check_eq("rom_read_enable", 32'(rom_read_enable), 32'((g0 || g1) && !gerr));
      check_eq("rom_address", 32'(rom_address), ((g0 || g1) && !gerr) ? 32'(gaddr) : 0);
      if (g0 || g1) begin
        e.port = g1;
        e.data = gerr ? 8'h00 : rom[gaddr];
        e.err  = gerr;
        sb.push_back(e);
        model_last = g1;
      end
    end
  end

  task automatic step(input logic v0, input logic [7:0] a0, input logic v1, input logic [7:0] a1);
    @(posedge clock);
    #1;
    req_valid_0   = v0;
    req_address_0 = a0;
    req_valid_1   = v1;
    req_address_1 = a1;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset_n     = 1'b0;
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'((i * 37 + 11) & 8'hff);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Single fetch requester.
    for (int i = 0; i < 4; i++) step(1'b1, 8'h03, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b0, 8'h00);

    // Dual requesters straight out of reset alternate starting with port 0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'h01, 1'b1, 8'h05);
      @(negedge clock);
      check_eq("alt_ready_0", 32'(req_ready_0), 32'((i % 2) == 0));
    end
    step(1'b0, 8'h00, 1'b0, 8'h00);

    // Port 1 alone, then contention goes to port 0.
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 8'h06);
    step(1'b1, 8'h02, 1'b1, 8'h06);
    @(negedge clock);
    check_eq("contest_first_ready_0", 32'(req_ready_0), 1);
    step(1'b1, 8'h02, 1'b1, 8'h06);
    step(1'b0, 8'h00, 1'b0, 8'h00);

    // Reset in the cycle after an accept drops the pending response.
    step(1'b1, 8'h04, 1'b0, 8'h00);
    do_reset();
    @(negedge clock);
    check_eq("post_rst_resp_valid_0", 32'(resp_valid_0), 0);

    // Idle stretch.
    step(1'b0, 8'h00, 1'b0, 8'h00);
    repeat (5) @(posedge clock);

`ifdef TAU_ROM_ARB_BOUNDS_CHECK_EN
    step(1'b1, 8'h09, 1'b0, 8'h00);
    step(1'b1, 8'h07, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b0, 8'h00);
`endif

    // Random mix.
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(1)), 8'($urandom_range(15)), 1'($urandom_range(1)),
           8'($urandom_range(15)));
    end
    step(1'b0, 8'h00, 1'b0, 8'h00);
    repeat (3) @(posedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares one synchronous-read ROM (1-cycle read latency, registered output) between two requesters:
  - port 0: instruction fetch
  - port 1: data load
- Sits between the core's fetch/load units and the ROM instance.
- Sequences ROM reads, arbitrates round-robin, and routes each returned word to the requester that issued it.
- Throughput: one read per cycle.

Parameters:
- ADDR_WIDTH, 8, width of requester and ROM address buses.
- DATA_WIDTH, 8, ROM word width.
- MEMORY_DEPTH, 8, number of valid ROM words. Used only by the optional bounds check.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid_0 / req_valid_1  in  1 each  requester has a read pending.
- req_address_0 / req_address_1  in  ADDR_WIDTH each  read address; held stable while valid and not ready.
- req_ready_0 / req_ready_1  out  1 each  request accepted this cycle (combinational).
- resp_valid_0 / resp_valid_1  out  1 each  response word valid this cycle.
- resp_data  out  DATA_WIDTH  shared response bus; qualified by resp_valid_x.
- rom_read_enable  out  1  to ROM read_enable.
- rom_address  out  ADDR_WIDTH  to ROM address.
- rom_data  in  DATA_WIDTH  from ROM data output.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low on reset_n.
- Reset values:
  - pend_valid=0, pend_id=0, last_grant=1, so port 0 wins the first contention.
  - All resp_valid_x=0.
- Grant (combinational, each cycle):
  - Only one port valid: that port is granted.
  - Both valid: grant the port != last_grant.
  - None valid: no grant.
  - req_ready_x = grant_x. No backpressure from the ROM; a request is always accepted when granted.
- Issue on grant:
  - rom_read_enable=1, rom_address = granted address.
  - When there is no grant: rom_read_enable=0, rom_address=0.
- Grant registers, at the clock edge:
  - last_grant <= granted id, only on a grant.
  - pend_valid <= any grant.
  - pend_id <= granted id.
- Response, one cycle after acceptance:
  - resp_valid_x = pend_valid && pend_id==x.
  - resp_data = rom_data when pend_valid, else 0.
  - Latency from req accept to resp_valid is exactly 1 cycle.
  - Back-to-back accepts give back-to-back responses.
  - Responses cannot be stalled; requesters must always sink them.
- Continuous dual request: grants alternate every cycle (0,1,0,1...). Neither port waits more than 1 cycle.
- Single requester: granted every cycle; last_grant still updates.
- Reset mid-operation: the pending response is dropped. No resp_valid is asserted in the cycle after reset release unless a new accept occurred.
- Exactly one of resp_valid_0/1 is high at most. Both high is an assertion failure.

Optional Feature:
- Macro: TAU_ROM_ARB_BOUNDS_CHECK_EN.
- Defined:
  - Adds output resp_error (1 bit).
  - A granted request with address >= MEMORY_DEPTH is accepted (ready=1) but not issued: rom_read_enable=0.
  - Next cycle: resp_valid_x=1, resp_data=0, resp_error=1.
  - pend carries an extra error bit; reset value 0.
  - resp_error=0 on all in-range responses.
- Undefined:
  - No resp_error port.
  - Every address is forwarded unchanged to the ROM.

Decomposition:
- Package tau_rom_pkg holds:
  - typedef rom_port_id_t (1 bit).
  - Constants ROM_PORT_FETCH=0, ROM_PORT_DATA=1.
  - Shared ADDR/DATA width defaults.
- One sub-module, rom_rr_arbiter2:
  - Inputs: valid_0/1, last_grant.
  - Outputs: grant_0/1, grant_id.
  - Purely combinational. The last_grant register stays in the parent.

Test Plan:
- After reset, hold req_valid_0=1 addr 0x03, port 1 idle -> ready_0=1 every cycle; resp_valid_0 one cycle later with resp_data=ROM[3].
- Both valid from reset, addr0=0x01, addr1=0x05, 4 cycles -> grants 0,1,0,1; responses alternate ROM[1],ROM[5],ROM[1],ROM[5], each 1 cycle after accept.
- Port 1 alone for 3 cycles, then both valid -> first contested grant goes to port 0, since last_grant=1.
- Assert reset_n low the cycle after an accept on port 0 -> resp_valid_0 stays 0 after release; rom_read_enable=0 during reset.
- No requests for 5 cycles -> rom_read_enable=0, all resp_valid=0, resp_data=0.
- With TAU_ROM_ARB_BOUNDS_CHECK_EN and MEMORY_DEPTH=8, port 0 addr 0x09 -> rom_read_enable=0; next cycle resp_valid_0=1, resp_error=1, resp_data=0. Then addr 0x07 gives resp_error=0 and data ROM[7].
